// File: rtl/frame_streamer.sv
// Streams NUM_LEDS pixels from RAM, scaled by a per-frame brightness, then holds a strip latch gap.
// Latency: frame_start edge -> mem_rd +1 cycle, pixel_valid +3; handshake -> next pixel_valid +3.
// Backpressure: pixel_data is held stable while pixel_valid && !pixel_ready; the RAM is read only on demand.
module frame_streamer #(
   parameter int NUM_LEDS     = 60,
   parameter int LATCH_CYCLES = 3000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_start,
   input  logic [7:0]  brightness,
   output logic [7:0]  mem_addr,
   output logic        mem_rd,
   input  logic [23:0] mem_data,
   output logic [23:0] pixel_data,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic        strip_latch,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  overrun_count
);

   localparam int              CW         = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam logic [7:0]      LAST_IDX   = 8'(NUM_LEDS - 1);
   localparam logic [CW-1:0]   LATCH_LOAD = CW'(LATCH_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, READ, LOAD, PRESENT, LATCH} state_t;

   state_t          state;
   logic [7:0]      index;
   logic [7:0]      bright_q;
   logic            fs_q;
   logic [CW-1:0]   latch_cnt;
   logic            fs_edge;

   assign fs_edge  = frame_start & ~fs_q;
   assign mem_addr = index;

   // One colour channel scaled by (bright+1)/256; 255 passes the value through unchanged.
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      logic [16:0] prod;
      prod = {9'd0, c} * ({9'd0, b} + 17'd1);
      prod = prod >> 8;
      return prod[7:0];
   endfunction

   // Frame sequencer: fetch, scale and present each pixel, then run the latch gap.
   // frame_done is raised in the last LATCH cycle so an edge landing on it is still seen as busy.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         index         <= 8'd0;
         bright_q      <= 8'd0;
         fs_q          <= 1'b0;
         latch_cnt     <= '0;
         mem_rd        <= 1'b0;
         pixel_data    <= 24'd0;
         pixel_valid   <= 1'b0;
         strip_latch   <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         overrun_count <= 8'd0;
      end else begin
         fs_q       <= frame_start;
         frame_done <= 1'b0;
         if (fs_edge && state != IDLE && overrun_count != 8'hFF)
            overrun_count <= overrun_count + 8'd1;
         case (state)
            IDLE: begin
               if (fs_edge) begin
                  index    <= 8'd0;
                  bright_q <= brightness;
                  mem_rd   <= 1'b1;
                  busy     <= 1'b1;
                  state    <= READ;
               end
            end
            READ: begin
               mem_rd <= 1'b0;
               state  <= LOAD;
            end
            LOAD: begin
               pixel_data  <= {scale(mem_data[23:16], bright_q),
                               scale(mem_data[15:8],  bright_q),
                               scale(mem_data[7:0],   bright_q)};
               pixel_valid <= 1'b1;
               state       <= PRESENT;
            end
            PRESENT: begin
               if (pixel_valid && pixel_ready) begin
                  pixel_valid <= 1'b0;
                  if (index == LAST_IDX) begin
                     latch_cnt   <= LATCH_LOAD;
                     strip_latch <= 1'b1;
                     frame_done  <= (LATCH_CYCLES == 1);
                     state       <= LATCH;
                  end else begin
                     index  <= index + 8'd1;
                     mem_rd <= 1'b1;
                     state  <= READ;
                  end
               end
            end
            LATCH: begin
               if (latch_cnt == '0) begin
                  strip_latch <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  latch_cnt  <= latch_cnt - CW'(1);
                  frame_done <= (latch_cnt == CW'(1));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: expected pixels queued at frame start, popped on handshake.
// Small latch gap and three LEDs keep every scenario short.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_frame_streamer;
   localparam int NL = 3;
   localparam int LC = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic [7:0]  brightness = 8'd0;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [23:0] mem_data = 24'd0;
   logic [23:0] pixel_data;
   logic        pixel_valid;
   logic        pixel_ready = 1'b0;
   logic        strip_latch;
   logic        busy;
   logic        frame_done;
   logic [7:0]  overrun_count;

   frame_streamer #(.NUM_LEDS(NL), .LATCH_CYCLES(LC)) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start), .brightness(brightness),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .strip_latch(strip_latch), .busy(busy), .frame_done(frame_done),
      .overrun_count(overrun_count));

   always #5 clock = ~clock;

   // RAM model: registered read, data one cycle after the strobe
   logic [23:0] ram [0:255];
   always @(posedge clock) if (mem_rd) mem_data <= ram[mem_addr];

   int checks = 0, errors = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [23:0] exp_q[$];
   int  done_cnt = 0, latch_cyc = 0, hs_cnt = 0, last_hs = 0;
   int  rd_cyc = -100, pv_cyc = -100, t0 = 0;
   logic [7:0] rd_addr = 8'hAA;
   bit  rd_arm = 0, pv_arm = 0, hs_pend = 0, pv_prev = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] ref_scale(input logic [23:0] w, input int b);
      int g, r, bl;
      g  = (int'(w[23:16]) * (b + 1)) / 256;
      r  = (int'(w[15:8])  * (b + 1)) / 256;
      bl = (int'(w[7:0])   * (b + 1)) / 256;
      return {g[7:0], r[7:0], bl[7:0]};
   endfunction

   // Output monitor and scoreboard
   always @(negedge clock) begin
      if (frame_done) done_cnt++;
      if (strip_latch) latch_cyc++;
      if (rd_arm && mem_rd) begin rd_arm = 0; rd_cyc = cyc; rd_addr = mem_addr; end
      if (pv_arm && pixel_valid) begin pv_arm = 0; pv_cyc = cyc; end
      if (pixel_valid && !pv_prev && hs_pend) begin
         chk("pix_gap", cyc - last_hs, 3);
         hs_pend = 0;
      end
      if (strip_latch || !reset) hs_pend = 0;
      if (pixel_valid && pixel_ready) begin
         hs_cnt++; last_hs = cyc; hs_pend = 1;
         if (exp_q.size() == 0) chk("pix_unexpected", 1, 0);
         else chk("pix", pixel_data, exp_q.pop_front());
      end
      pv_prev = pixel_valid;
   end

   task automatic start_frame();
      @(posedge clock); #1;
      t0 = cyc; rd_cyc = -100; pv_cyc = -100; rd_arm = 1; pv_arm = 1;
      frame_start = 1'b1;
      @(posedge clock); #1;
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < budget) begin @(negedge clock); n++; end
      chk("done_timeout", done_cnt != d0, 1);
      repeat (2) @(negedge clock);
   endtask

   task automatic push_frame(input int b);
      for (int i = 0; i < NL; i++) exp_q.push_back(ref_scale(ram[i], b));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, l0, h0, o0, n;
      bit stable;
      logic [23:0] cap;
      for (int i = 0; i < 256; i++) ram[i] = 24'd0;
      ram[0] = 24'h102030; ram[1] = 24'h405060; ram[2] = 24'h708090;

      #1 reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_pixel_data", pixel_data, 0);
      chk("rst_pixel_valid", pixel_valid, 0);
      chk("rst_strip_latch", strip_latch, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overrun", overrun_count, 0);
      @(posedge clock); #1 reset = 1'b1;

      // full-brightness frame, always ready
      brightness = 8'd255; pixel_ready = 1'b1;
      exp_q.push_back(24'h102030); exp_q.push_back(24'h405060); exp_q.push_back(24'h708090);
      d0 = done_cnt; l0 = latch_cyc; h0 = hs_cnt;
      start_frame();
      wait_done(200);
      chk("f1_rd_lat", rd_cyc - t0, 1);
      chk("f1_pv_lat", pv_cyc - t0, 3);
      chk("f1_rd_addr", rd_addr, 0);
      chk("f1_latch_len", latch_cyc - l0, LC);
      chk("f1_done_cnt", done_cnt - d0, 1);
      chk("f1_pixels", hs_cnt - h0, NL);
      chk("f1_busy_idle", busy, 0);

      // half brightness; a mid-frame brightness change must not matter
      ram[0] = 24'hFF8001; ram[1] = 24'h123456; ram[2] = 24'hFFFFFF;
      brightness = 8'd127;
      exp_q.push_back(24'h7F4000); exp_q.push_back(ref_scale(ram[1], 127)); exp_q.push_back(24'h7F7F7F);
      start_frame();
      brightness = 8'd0;
      wait_done(200);

      // zero brightness; raising it mid-frame must not matter
      brightness = 8'd0;
      exp_q.push_back(24'h0); exp_q.push_back(24'h0); exp_q.push_back(24'h0);
      start_frame();
      brightness = 8'd255;
      wait_done(200);

      // edge landing on the frame_done cycle is an overrun
      ram[0] = 24'h102030; ram[1] = 24'h405060; ram[2] = 24'h708090;
      push_frame(255);
      o0 = overrun_count;
      start_frame();
      n = 0;
      while (!strip_latch && n < 200) begin @(negedge clock); n++; end
      chk("latch_timeout", strip_latch, 1);
      repeat (LC - 1) @(negedge clock);
      chk("done_cycle", frame_done, 1);
      frame_start = 1'b1;
      repeat (3) @(negedge clock);
      frame_start = 1'b0;
      chk("overrun_on_done", overrun_count, o0 + 1);
      chk("no_restart", busy, 0);

      // stall in PRESENT with edges arriving, then a single ready pulse
      pixel_ready = 1'b0;
      push_frame(255);
      d0 = done_cnt;
      start_frame();
      n = 0;
      while (!pixel_valid && n < 50) begin @(negedge clock); n++; end
      cap = pixel_data; stable = 1; o0 = overrun_count; h0 = hs_cnt;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (!pixel_valid || pixel_data !== cap) stable = 0;
         if (i == 10 || i == 20 || i == 30) frame_start = 1'b1;
         if (i == 12 || i == 22 || i == 32) frame_start = 1'b0;
      end
      chk("stall_stable", stable, 1);
      chk("stall_data", cap, 24'h102030);
      chk("stall_overrun", overrun_count - o0, 3);
      chk("stall_no_hs", hs_cnt - h0, 0);
      @(posedge clock); #1 pixel_ready = 1'b1;
      @(posedge clock); #1 pixel_ready = 1'b0;
      repeat (10) @(negedge clock);
      chk("pulse_one_hs", hs_cnt - h0, 1);
      chk("pulse_addr", mem_addr, 1);
      chk("pulse_next_valid", pixel_valid, 1);
      for (int i = 0; i < 300; i++) begin
         @(posedge clock); #1 frame_start = 1'b1;
         @(posedge clock); #1 frame_start = 1'b0;
      end
      @(negedge clock);
      chk("overrun_sat", overrun_count, 255);
      pixel_ready = 1'b1;
      wait_done(200);
      chk("stall_one_done", done_cnt - d0, 1);

      // reset during pixel 1 abandons the frame
      push_frame(255);
      start_frame();
      n = 0;
      while (mem_addr != 8'd1 && n < 50) begin @(negedge clock); n++; end
      #2 reset = 1'b0;
      #1;
      chk("arst_mem_addr", mem_addr, 0);
      chk("arst_mem_rd", mem_rd, 0);
      chk("arst_pixel_valid", pixel_valid, 0);
      chk("arst_pixel_data", pixel_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_overrun", overrun_count, 0);
      exp_q.delete();
      d0 = done_cnt; l0 = latch_cyc;
      frame_start = 1'b1;
      repeat (5) @(negedge clock);
      chk("arst_no_done", done_cnt - d0, 0);
      chk("arst_no_latch", latch_cyc - l0 + int'(strip_latch), 0);
      // frame_start already high at release counts as an edge
      push_frame(255);
      @(posedge clock); #1;
      t0 = cyc; rd_cyc = -100; rd_arm = 1;
      reset = 1'b1;
      @(posedge clock); #1 frame_start = 1'b0;
      wait_done(200);
      chk("restart_rd_lat", rd_cyc - t0, 1);
      chk("restart_addr", rd_addr, 0);
      chk("sb_empty_end", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/frame_streamer.md
FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 Parameter NUM_LEDS, default 60, number of pixels sent per frame (1..256).
REQ-002 Parameter LATCH_CYCLES, default 3000, number of clock cycles the strip latch gap lasts after the last pixel.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset; all other inputs are synchronous to clock.
REQ-004 clock  in  1  system clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-006 frame_start  in  1  framerate tick; a rising edge requests one frame.
REQ-007 brightness  in  8  global scale factor; 255 = unscaled.
REQ-008 mem_addr  out  8  pixel RAM read address.
REQ-009 mem_rd  out  1  RAM read strobe; data is valid on mem_data exactly 1 cycle later.
REQ-010 mem_data  in  24  pixel word from RAM, GRB order, G in [23:16].
REQ-011 pixel_data  out  24  scaled pixel word to the xx6812 encoder.
REQ-012 pixel_valid  out  1  pixel_data holds an unconsumed pixel.
REQ-013 pixel_ready  in  1  encoder accepts pixel_data this cycle.
REQ-014 strip_latch  out  1  high during the latch gap; drives the encoder reset.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frame_done  out  1  one-cycle pulse when a frame completes.
REQ-017 overrun_count  out  8  saturating count of frame requests ignored while busy.

Function
REQ-018 The state machine SHALL have the states IDLE, READ, LOAD, PRESENT and LATCH.
REQ-019 frame_start SHALL be registered each cycle; an edge is current sample 1 and previous sample 0.
REQ-020 An edge in IDLE: index := 0, brightness sampled into bright_q, next state READ.
REQ-021 READ: mem_rd = 1 and mem_addr = index for exactly 1 cycle; next state LOAD.
REQ-022 mem_rd SHALL be 0 in all states other than READ; mem_addr SHALL hold index at all times.
REQ-023 LOAD: each 8-bit channel c of mem_data is scaled to (c * (bright_q + 1)) >> 8, computed at 17-bit width and truncated to 8 bits, then registered into pixel_data; next state PRESENT.
REQ-024 Scaling consequences: bright_q = 255 SHALL give an identity result and bright_q = 0 SHALL give c >> 8, which is 0.
REQ-025 PRESENT: pixel_valid = 1, and pixel_data SHALL stay stable until pixel_valid && pixel_ready.
REQ-026 On a handshake with index < NUM_LEDS-1: index increments and the next state is READ, with pixel_valid low for the 2 refill cycles.
REQ-027 On a handshake with index = NUM_LEDS-1: the next state is LATCH, the latch counter loads LATCH_CYCLES-1, and pixel_valid is 0 the following cycle.
REQ-028 Latency: an edge sampled at cycle N SHALL give mem_rd at N+1 and pixel_valid at N+3.
REQ-029 Latency between pixels: a handshake at cycle M SHALL give the next pixel_valid at M+3.
REQ-030 LATCH: strip_latch = 1 for exactly LATCH_CYCLES cycles while the counter decrements to 0.
REQ-031 At counter = 0 in LATCH: frame_done pulses 1 cycle and the next state is IDLE.
REQ-032 brightness changes during a frame SHALL have no effect; bright_q holds until the next frame.
REQ-033 An edge detected in any non-IDLE state SHALL be dropped and overrun_count SHALL increment, saturating at 255.
REQ-034 A frame_start edge coinciding with the frame_done cycle SHALL count as an overrun, not start a frame.
REQ-035 pixel_ready while pixel_valid = 0 SHALL be ignored.
REQ-036 NUM_LEDS = 1: one READ/LOAD/PRESENT pass, then LATCH.

Reset
REQ-037 While reset = 0, the following SHALL hold:
- state IDLE, index 0, bright_q 0;
- mem_addr 0, mem_rd 0;
- pixel_data 0, pixel_valid 0;
- strip_latch 0, busy 0, frame_done 0, overrun_count 0;
- frame_start history register 0.
REQ-038 Reset asserted mid-frame SHALL abandon the frame, with no frame_done and no latch.
REQ-039 After reset release, a frame_start already high SHALL count as an edge on the first clock.

Verification
REQ-040 NUM_LEDS=3, RAM[0..2]=0x102030/0x405060/0x708090, brightness=255, pixel_ready=1 -> pixel_data sequence 0x102030, 0x405060, 0x708090, each 3 cycles apart; strip_latch high for LATCH_CYCLES; one frame_done.
REQ-041 brightness=127, RAM[0]=0xFF8001 -> pixel_data=0x7F4000.
REQ-042 brightness=0 -> pixel_data=0x000000.
REQ-043 pixel_ready held 0 for 50 cycles in PRESENT -> pixel_valid stays 1 and pixel_data is unchanged; a single ready pulse advances exactly one pixel.
REQ-044 Three frame_start edges during one frame -> overrun_count=3 and only one frame_done; 300 edges while busy -> overrun_count stays at 255.
REQ-045 reset=0 during pixel 1 of a frame -> all outputs take their reset values asynchronously; the next edge restarts at mem_addr 0.
